// File: rtl/ahb_pkg.sv
// Shared AHB types for the arbiter: transfer/burst encodings, arbiter states,
// and the beat-count helper for fixed-length bursts.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    ST_FREE  = 2'b00,
    ST_BURST = 2'b01,
    ST_LOCK  = 2'b10
  } arb_state_t;

  // Undefined-length INCR reports 0 so it never looks like a fixed burst.
  function automatic logic [4:0] burst_beats(hburst_t b);
    logic [4:0] n;
    case (b)
      HB_SINGLE:           n = 5'd1;
      HB_INCR:             n = 5'd0;
      HB_WRAP4,  HB_INCR4:  n = 5'd4;
      HB_WRAP8,  HB_INCR8:  n = 5'd8;
      HB_WRAP16, HB_INCR16: n = 5'd16;
      default:             n = 5'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// Round-robin request picker: first requester after `last`, wrapping modulo N,
// so the master at `last` is considered only after every other one.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!valid && |(req & (N'(1) << idx))) begin
        valid  = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin one-hot grant, burst/lock protection, and the
// registered Hmaster/Hmastlock that steer the master-to-slave mux.
`ifndef NUM_MASTERS
`define NUM_MASTERS 2
`endif

module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = `NUM_MASTERS,
  parameter int DEFAULT_MASTER = 0,
  parameter int MASTER_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                    Hclk,
  input  logic                    Hresetn,
  input  logic [NUM_MASTERS-1:0]  Hbusreq,
  input  logic [NUM_MASTERS-1:0]  Hlock,
  input  logic [1:0]              Htrans,
  input  logic [2:0]              Hburst,
  input  logic                    Hready,
  output logic [NUM_MASTERS-1:0]  Hgrant,
  output logic [MASTER_WIDTH-1:0] Hmaster,
  output logic                    Hmastlock,
  output logic [1:0]              state_dbg
);

  localparam logic [MASTER_WIDTH-1:0] DEF_IDX   = MASTER_WIDTH'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]  DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_t              state, state_n;
  logic [3:0]              cnt, cnt_n;
  // Round-robin pointer; it always names the grant owner, so the owner is
  // searched last and continuous requesters alternate.
  logic [MASTER_WIDTH-1:0] last;

  logic [MASTER_WIDTH-1:0] pick_idx, win_idx;
  logic                    pick_valid;
  logic [NUM_MASTERS-1:0]  win_grant;
  logic                    lock_own;
  logic                    accepted, burst_start, rearb;
  logic [4:0]              beats;

  rr_picker #(
    .N (NUM_MASTERS),
    .W (MASTER_WIDTH)
  ) u_picker (
    .req    (Hbusreq),
    .last   (last),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign win_idx   = pick_valid ? pick_idx : DEF_IDX;
  assign win_grant = NUM_MASTERS'(1) << win_idx;
  assign lock_own  = |(Hlock & Hgrant);
  assign state_dbg = state;

  // Ownership and every counter move only on Hready=1 edges; Hready=0 stalls all.
  always_comb begin
    accepted    = Hready && (Htrans == HT_NONSEQ || Htrans == HT_SEQ);
    beats       = burst_beats(hburst_t'(Hburst));
    burst_start = accepted && (Htrans == HT_NONSEQ) && (beats > 5'd1);
    state_n     = state;
    cnt_n       = cnt;
    rearb       = 1'b0;
    if (Hready) begin
      unique case (state)
        ST_FREE, ST_LOCK: begin
          if (burst_start) begin
            state_n = ST_BURST;
            cnt_n   = 4'(beats - 5'd1);
          end else if (lock_own) begin
            state_n = ST_LOCK;
          end else begin
            state_n = ST_FREE;
            rearb   = 1'b1;
          end
        end
        ST_BURST: begin
          if (burst_start) begin
            cnt_n = 4'(beats - 5'd1);
          end else if (Htrans == HT_IDLE) begin
            state_n = ST_FREE;
            cnt_n   = 4'd0;
          end else if (accepted && Htrans == HT_SEQ) begin
            if (cnt <= 4'd1) begin
              // Last beat's address: hand over in this same cycle unless locked.
              cnt_n = 4'd0;
              if (lock_own) begin
                state_n = ST_LOCK;
              end else begin
                state_n = ST_FREE;
                rearb   = 1'b1;
              end
            end else begin
              cnt_n = cnt - 4'd1;
            end
          end else if (accepted) begin
            state_n = ST_FREE;
            cnt_n   = 4'd0;
          end
        end
        default: begin
          state_n = ST_FREE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Hgrant    <= DEF_GRANT;
      Hmaster   <= DEF_IDX;
      Hmastlock <= 1'b0;
      last      <= DEF_IDX;
      cnt       <= 4'd0;
      state     <= ST_FREE;
    end else if (Hready) begin
      state     <= state_n;
      cnt       <= cnt_n;
      Hmaster   <= last;
      Hmastlock <= lock_own;
      if (rearb) begin
        Hgrant <= win_grant;
        last   <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (2 masters): reset, round-robin, bursts with
// and without wait states, lock, abandoned burst and asynchronous reset.
module tb_ahb_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_INCR8 = 3'b101;
  localparam logic [1:0] S_FREE = 2'b00, S_BURST = 2'b01, S_LOCK = 2'b10;

  logic       Hclk = 1'b0;
  logic       Hresetn = 1'b0;
  logic [1:0] Hbusreq = '0;
  logic [1:0] Hlock = '0;
  logic [1:0] Htrans = T_IDLE;
  logic [2:0] Hburst = B_SINGLE;
  logic       Hready = 1'b1;
  logic [1:0] Hgrant;
  logic       Hmaster;
  logic       Hmastlock;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];

  ahb_arbiter #(.NUM_MASTERS(2), .DEFAULT_MASTER(0)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hbusreq   (Hbusreq),
    .Hlock     (Hlock),
    .Htrans    (Htrans),
    .Hburst    (Hburst),
    .Hready    (Hready),
    .Hgrant    (Hgrant),
    .Hmaster   (Hmaster),
    .Hmastlock (Hmastlock),
    .state_dbg (state_dbg)
  );

  // Clock/reset block
  always #5 Hclk = ~Hclk;

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] lck,
                       input logic [1:0] trans, input logic [2:0] burst,
                       input logic rdy);
    Hbusreq = req;
    Hlock   = lck;
    Htrans  = trans;
    Hburst  = burst;
    Hready  = rdy;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0;
    drive(2'b00, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    tick();
    Hresetn = 1'b1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] g, input logic m, input logic ml);
    check_val({tag, "_grant"}, 32'(Hgrant), 32'(g));
    check_val({tag, "_master"}, 32'(Hmaster), 32'(m));
    check_val({tag, "_mastlock"}, 32'(Hmastlock), 32'(ml));
  endtask

  initial begin
    logic [2:0] e;

    // Reset / default master
    do_reset();
    Hresetn = 1'b0;
    #1;
    check_out("rst", 2'b01, 1'b0, 1'b0);
    check_val("rst_state", 32'(state_dbg), 32'(S_FREE));
    Hresetn = 1'b1;
    tick();
    check_out("idle1", 2'b01, 1'b0, 1'b0);
    tick();
    check_out("idle2", 2'b01, 1'b0, 1'b0);

    // Round-robin with SINGLE transfers: grant alternates, Hmaster one edge behind
    do_reset();
    drive(2'b11, 2'b00, T_NONSEQ, B_SINGLE, 1'b1);
    exp_q.push_back({2'b10, 1'b0});
    exp_q.push_back({2'b01, 1'b1});
    exp_q.push_back({2'b10, 1'b0});
    exp_q.push_back({2'b01, 1'b1});
    exp_q.push_back({2'b10, 1'b0});
    exp_q.push_back({2'b01, 1'b1});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check_val("rr_grant", 32'(Hgrant), 32'(e[2:1]));
      check_val("rr_master", 32'(Hmaster), 32'(e[0]));
    end
    check_val("rr_state", 32'(state_dbg), 32'(S_FREE));

    // INCR4 by master 0, master 1 requesting from beat 1
    do_reset();
    drive(2'b01, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check_out("b4_own", 2'b01, 1'b0, 1'b0);
    drive(2'b11, 2'b00, T_NONSEQ, B_INCR4, 1'b1);
    tick();
    check_val("b4_beat1_grant", 32'(Hgrant), 32'h1);
    check_val("b4_beat1_state", 32'(state_dbg), 32'(S_BURST));
    drive(2'b10, 2'b00, T_SEQ, B_INCR4, 1'b1);
    tick();
    check_val("b4_beat2_grant", 32'(Hgrant), 32'h1);
    tick();
    check_val("b4_beat3_grant", 32'(Hgrant), 32'h1);
    tick();
    check_out("b4_beat4", 2'b10, 1'b0, 1'b0);
    check_val("b4_beat4_state", 32'(state_dbg), 32'(S_FREE));
    drive(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check_out("b4_handover", 2'b10, 1'b1, 1'b0);

    // Same INCR4 with 3 wait states at beat 2
    do_reset();
    drive(2'b01, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    drive(2'b11, 2'b00, T_NONSEQ, B_INCR4, 1'b1);
    tick();
    drive(2'b10, 2'b00, T_SEQ, B_INCR4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("ws_hold", 2'b01, 1'b0, 1'b0);
      check_val("ws_state", 32'(state_dbg), 32'(S_BURST));
    end
    Hready = 1'b1;
    tick();
    check_val("ws_beat2_grant", 32'(Hgrant), 32'h1);
    tick();
    check_val("ws_beat3_grant", 32'(Hgrant), 32'h1);
    tick();
    check_out("ws_beat4", 2'b10, 1'b0, 1'b0);

    // Lock: master 1 locks while master 0 requests
    do_reset();
    drive(2'b11, 2'b10, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check_out("lk_grant", 2'b10, 1'b0, 1'b0);
    tick();
    check_out("lk_enter", 2'b10, 1'b1, 1'b1);
    check_val("lk_state", 32'(state_dbg), 32'(S_LOCK));
    drive(2'b11, 2'b10, T_NONSEQ, B_SINGLE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("lk_hold", 2'b10, 1'b1, 1'b1);
    end
    drive(2'b01, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    check_out("lk_release", 2'b01, 1'b1, 1'b0);
    check_val("lk_rel_state", 32'(state_dbg), 32'(S_FREE));
    tick();
    check_out("lk_after", 2'b01, 1'b0, 1'b0);

    // Abandoned INCR8: IDLE after beat 3
    do_reset();
    drive(2'b01, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    tick();
    drive(2'b11, 2'b00, T_NONSEQ, B_INCR8, 1'b1);
    tick();
    drive(2'b11, 2'b00, T_SEQ, B_INCR8, 1'b1);
    tick();
    tick();
    check_val("ab_beat3_grant", 32'(Hgrant), 32'h1);
    check_val("ab_beat3_state", 32'(state_dbg), 32'(S_BURST));
    drive(2'b10, 2'b00, T_IDLE, B_INCR8, 1'b1);
    tick();
    check_val("ab_idle_state", 32'(state_dbg), 32'(S_FREE));
    check_val("ab_idle_grant", 32'(Hgrant), 32'h1);
    tick();
    check_val("ab_next_grant", 32'(Hgrant), 32'h2);

    // Asynchronous reset at beat 5 of a locked INCR8 by master 1
    do_reset();
    drive(2'b10, 2'b10, T_IDLE, B_SINGLE, 1'b1);
    tick();
    tick();
    check_out("ar_locked", 2'b10, 1'b1, 1'b1);
    drive(2'b10, 2'b10, T_NONSEQ, B_INCR8, 1'b1);
    tick();
    drive(2'b10, 2'b10, T_SEQ, B_INCR8, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check_out("ar_beat5", 2'b10, 1'b1, 1'b1);
    check_val("ar_beat5_state", 32'(state_dbg), 32'(S_BURST));
    #2;
    Hresetn = 1'b0;
    #1;
    check_out("ar_async", 2'b01, 1'b0, 1'b0);
    check_val("ar_async_state", 32'(state_dbg), 32'(S_FREE));
    tick();
    drive(2'b10, 2'b00, T_IDLE, B_SINGLE, 1'b1);
    Hresetn = 1'b1;
    tick();
    check_out("ar_first", 2'b10, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Bus arbiter for the multi-master AHB interconnect. It collects bus requests and lock requests from every master and issues one-hot grants. It then drives the registered `Hmaster` index that steers the master-to-slave address/control/write-data mux. Arbitration is round-robin, and fixed-length bursts and locked sequences are never broken. Ownership changes only on `Hready`.

## Interface
Parameters:
- `NUM_MASTERS`, default `` `NUM_MASTERS `` (2): number of masters; must be ≥1.
- `DEFAULT_MASTER`, default 0: master granted when nobody requests.
- `MASTER_WIDTH`, default `(NUM_MASTERS>1)?$clog2(NUM_MASTERS):1`: width of the index. Derived; do not override.

Ports:
- `Hclk`  in  1  sole clock, rising edge.
- `Hresetn`  in  1  asynchronous, active-low reset.
- `Hbusreq`  in  [NUM_MASTERS]  per-master bus request.
- `Hlock`  in  [NUM_MASTERS]  per-master locked-transfer request.
- `Htrans`  in  2  bus transfer type, taken from the mux output (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `Hburst`  in  3  bus burst type, taken from the mux output.
- `Hready`  in  1  bus ready, taken from the slave-to-master mux.
- `Hgrant`  out  [NUM_MASTERS]  one-hot grant, registered.
- `Hmaster`  out  MASTER_WIDTH  index of the address-phase owner, registered; drives the mux select.
- `Hmastlock`  out  1  current address phase is locked, registered.

## Operation
Reset values:
- `Hgrant` is one-hot on `DEFAULT_MASTER`.
- `Hmaster` is `DEFAULT_MASTER`.
- `Hmastlock` is 0.
- Round-robin pointer `last` is `DEFAULT_MASTER`.
- Beat counter `cnt` is 0.
- State is `ST_FREE`.

States:
- `ST_FREE`: re-arbitration is allowed.
- `ST_BURST`: a fixed-length burst is in progress.
- `ST_LOCK`: the granted master holds `Hlock`.

An "accepted" transfer is one where `Hready`=1 with `Htrans` = NONSEQ or SEQ.

Beat counter, updated on an accepted transfer:
- NONSEQ with `Hburst` INCR4/WRAP4, INCR8/WRAP8 or INCR16/WRAP16 loads `cnt` with 3, 7 or 15 respectively, and the state goes to `ST_BURST`.
- SEQ decrements `cnt`. When `cnt` reaches 0, the state returns to `ST_FREE`, or to `ST_LOCK` if the owner's `Hlock` is set.
- SINGLE and INCR (undefined length) never enter `ST_BURST`.

Other counter rules:
- `Htrans`=IDLE in `ST_BURST` means the burst was abandoned: clear `cnt` and go to `ST_FREE`.
- BUSY holds `cnt` unchanged.

Re-arbitration point:
- A re-arbitration point is a cycle with `Hready`=1 and state `ST_FREE`.
- It is also the cycle in `ST_BURST` whose accepted SEQ takes `cnt` from 1 to 0, i.e. the last beat's address.
- At that point `Hgrant` updates to the winner.

Winner selection:
- The winner is the first requester searching `last+1`, `last+2`, … modulo `NUM_MASTERS`.
- The current owner is eligible only after all others have been checked, so requests are fair and grants are not sticky.
- If no master requests, the winner is `DEFAULT_MASTER`.

Lock:
- While the granted master asserts `Hlock`, the state is `ST_LOCK` and the grant is frozen regardless of other requests.
- Deasserting `Hlock` returns the state to `ST_FREE` at the next `Hready` cycle.
- Requests from other masters never interrupt `ST_LOCK` or `ST_BURST`.

On every rising edge with `Hready`=1:
- `Hmaster` takes the index of the current `Hgrant`.
- `Hmastlock` takes the `Hlock` of that master.
- `last` updates to the new `Hmaster`.

With `Hready`=0, all registers hold.

## Timing
- A request asserted in cycle N at a re-arbitration point gives `Hgrant` at edge N+1.
- `Hmaster` follows at the first `Hready`=1 edge after the grant, at the earliest N+2. The new master's NONSEQ address therefore reaches the mux in the cycle `Hmaster` changes.
- Grant changes in the same cycle as the last burst beat's address, so there are zero dead cycles between back-to-back bursts of different masters.
- Simultaneous requests are resolved by the round-robin order only.
- A simultaneous `Hlock` and request at a re-arbitration point is granted normally, and the state enters `ST_LOCK` once that master owns the grant.
- Wait states (`Hready`=0) stretch every phase; `cnt` does not move.
- Reset asserted mid-burst or mid-lock forces all reset values immediately, asynchronously. The first post-reset grant follows the normal rules.
- `NUM_MASTERS`=1: `Hgrant` is constant 1 and `Hmaster` is constant 0; lock and burst logic is still present.

## Structure
- Shared package `ahb_pkg` holds:
  - `htrans_t` and `hburst_t` enums, with the encodings above.
  - `burst_beats(hburst_t)`, returning 1/4/8/16 and 0 for INCR.
  - the `arb_state_t` enum.
- One sub-module, `rr_picker`: combinational, inputs request vector and `last`, output the winner index and a valid flag.
- The arbiter itself holds the FSM, the beat counter and the output registers.

## Test plan
- **Reset/default:** assert `Hresetn`=0 with all requests low → `Hgrant`=0b01, `Hmaster`=0, `Hmastlock`=0. Keep requests low after release → grant stays on `DEFAULT_MASTER`.
- **Round-robin:** masters 0 and 1 request continuously with SINGLE NONSEQ transfers and `Hready`=1 → grant alternates 0,1,0,1. `Hmaster` lags the grant by one cycle.
- **Fixed burst:** master 0 issues INCR4 and master 1 requests from beat 1 → the grant moves to 1 only in the cycle of beat 4's address (`cnt` 1→0). Master 1's NONSEQ follows with no IDLE gap.
- **Wait states:** the same INCR4 with `Hready`=0 for 3 cycles at beat 2 → `cnt`, `Hgrant` and `Hmaster` hold. The handover shifts by exactly 3 cycles.
- **Lock:** master 1 holds `Hlock` for 5 transfers while master 0 requests → grant stays on 1 and `Hmastlock`=1 with `Hmaster`. Master 0 is granted at the first `Hready` edge after `Hlock` drops.
- **Abandon/reset:** master 0 has an INCR8 at beat 3 and drives IDLE → `ST_FREE`, and a pending master 1 is granted next edge. Separately, asserting `Hresetn` at beat 5 of a burst → all outputs return to reset values asynchronously.
